// File: rtl/decode_fwd_ctrl_pkg.sv
// Shared pipeline definitions for the decode-stage forwarding controller.
// Contents:
//   PIPE_XLEN      default datapath width
//   REG_W          architectural register index width
//   shadow_entry_t bookkeeping record for one in-flight instruction
//   SH_EMPTY       an invalid (bubble) shadow entry
//   rd_match()     true when an entry produces the given nonzero source register
package decode_fwd_ctrl_pkg;

  localparam int PIPE_XLEN = 32;
  localparam int REG_W     = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_load;
  } shadow_entry_t;

  localparam shadow_entry_t SH_EMPTY = '{valid: 1'b0, rd: {REG_W{1'b0}},
                                         reg_write: 1'b0, is_load: 1'b0};

  // x0 is hard-wired to zero, so it never counts as a produced value.
  function automatic logic rd_match(input shadow_entry_t e, input logic [REG_W-1:0] rs);
    return e.valid & e.reg_write & (e.rd == rs) & (rs != {REG_W{1'b0}});
  endfunction

endpackage

// File: rtl/decode_fwd_ctrl_if.sv
// Decode-stage bus between the pipeline and the forwarding controller.
// master: pipeline side, drives D-stage fields, flush and E/M/W data,
//         receives the selects, forwarded data and hazard controls.
// slave : controller side, the mirror image.
interface decode_fwd_ctrl_if
  import decode_fwd_ctrl_pkg::*;
#(
  parameter int XLEN  = PIPE_XLEN,
  parameter int CNT_W = 32
);

  logic             D_valid;
  logic [REG_W-1:0] D_rs1_addr;
  logic [REG_W-1:0] D_rs2_addr;
  logic             D_rs1_used;
  logic             D_rs2_used;
  logic [REG_W-1:0] D_rd;
  logic             D_reg_write;
  logic             D_is_load;
  logic             flush;
  logic [XLEN-1:0]  E_alu_out;
  logic [XLEN-1:0]  M_data;
  logic [XLEN-1:0]  W_data;

  logic             D_rs1_sel;
  logic             D_rs2_sel;
  logic [XLEN-1:0]  f_rs1_data_out;
  logic [XLEN-1:0]  f_rs2_data_out;
  logic             stall;
  logic             E_bubble;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
           D_rd, D_reg_write, D_is_load, flush, E_alu_out, M_data, W_data,
    input  D_rs1_sel, D_rs2_sel, f_rs1_data_out, f_rs2_data_out,
           stall, E_bubble, stall_cnt
  );

  modport slave (
    input  D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
           D_rd, D_reg_write, D_is_load, flush, E_alu_out, M_data, W_data,
    output D_rs1_sel, D_rs2_sel, f_rs1_data_out, f_rs2_data_out,
           stall, E_bubble, stall_cnt
  );

endinterface

// File: rtl/decode_fwd_ctrl_fwd_lookup.sv
// Per-operand forwarding lookup against the E/M/W shadow entries.
// Inputs : rs (source index), used, sh_e/sh_m/sh_w, e_data/m_data/w_data
// Outputs: sel (forward this operand), data (forwarded value),
//          load_use (youngest producer is a load still in E)
module fwd_lookup
  import decode_fwd_ctrl_pkg::*;
#(
  parameter int XLEN = PIPE_XLEN
) (
  input  logic [REG_W-1:0] rs,
  input  logic             used,
  input  shadow_entry_t    sh_e,
  input  shadow_entry_t    sh_m,
  input  shadow_entry_t    sh_w,
  input  logic [XLEN-1:0]  e_data,
  input  logic [XLEN-1:0]  m_data,
  input  logic [XLEN-1:0]  w_data,
  output logic             sel,
  output logic [XLEN-1:0]  data,
  output logic             load_use
);

  logic hit_e_s;
  logic hit_m_s;
  logic hit_w_s;
  logic unused_load_bits_s;

  assign hit_e_s = used & rd_match(sh_e, rs);
  assign hit_m_s = used & rd_match(sh_m, rs);
  assign hit_w_s = used & rd_match(sh_w, rs);

  // Only the E entry can still be waiting on memory; M and W results are ready.
  assign unused_load_bits_s = sh_m.is_load ^ sh_w.is_load;

  // Youngest producer wins; a load in E defers to the older M/W lookup
  // so the select is already meaningful while the stall is asserted.
  always_comb begin
    sel      = 1'b0;
    data     = {XLEN{1'b0}};
    load_use = 1'b0;
    if (hit_e_s && !sh_e.is_load) begin
      sel  = 1'b1;
      data = e_data;
    end else begin
      load_use = hit_e_s;
      if (hit_m_s) begin
        sel  = 1'b1;
        data = m_data;
      end else if (hit_w_s) begin
        sel  = 1'b1;
        data = w_data;
      end else begin
        sel  = 1'b0;
        data = {XLEN{1'b0}};
      end
    end
  end

endmodule

// File: rtl/decode_fwd_ctrl.sv
// Decode-stage forwarding and hazard controller.
// Ports: clk, rst_n (async, active-low), bus (decode_fwd_ctrl_if.slave)
//   bus inputs : D-stage fields, flush, E_alu_out, M_data, W_data
//   bus outputs: D_rs*_sel, f_rs*_data_out, stall, E_bubble, stall_cnt
// Keeps a shadow copy of the destination registers in E, M and W, forwards
// the youngest matching result and stalls one cycle on load-use.
module decode_fwd_ctrl
  import decode_fwd_ctrl_pkg::*;
#(
  parameter int XLEN  = PIPE_XLEN,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  decode_fwd_ctrl_if.slave bus
);

  shadow_entry_t    sh_e_q, sh_e_d;
  shadow_entry_t    sh_m_q, sh_m_d;
  shadow_entry_t    sh_w_q, sh_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             rs1_sel_s, rs2_sel_s;
  logic [XLEN-1:0]  rs1_data_s, rs2_data_s;
  logic             rs1_lu_s, rs2_lu_s;
  logic             stall_s, e_bubble_s;

  fwd_lookup #(.XLEN(XLEN)) u_rs1 (
    .rs(bus.D_rs1_addr), .used(bus.D_rs1_used),
    .sh_e(sh_e_q), .sh_m(sh_m_q), .sh_w(sh_w_q),
    .e_data(bus.E_alu_out), .m_data(bus.M_data), .w_data(bus.W_data),
    .sel(rs1_sel_s), .data(rs1_data_s), .load_use(rs1_lu_s)
  );

  fwd_lookup #(.XLEN(XLEN)) u_rs2 (
    .rs(bus.D_rs2_addr), .used(bus.D_rs2_used),
    .sh_e(sh_e_q), .sh_m(sh_m_q), .sh_w(sh_w_q),
    .e_data(bus.E_alu_out), .m_data(bus.M_data), .w_data(bus.W_data),
    .sel(rs2_sel_s), .data(rs2_data_s), .load_use(rs2_lu_s)
  );

  // Hazard controls: a flush kills the dependent instruction, so it overrides the stall.
  always_comb begin
    stall_s    = bus.D_valid & ~bus.flush & (rs1_lu_s | rs2_lu_s);
    e_bubble_s = stall_s | bus.flush;
  end

  // Shadow advance: a stalled or flushed D instruction enters E as a bubble.
  always_comb begin
    sh_w_d = sh_m_q;
    sh_m_d = sh_e_q;
    if (bus.D_valid && !stall_s && !bus.flush) begin
      sh_e_d = '{valid: 1'b1, rd: bus.D_rd,
                 reg_write: bus.D_reg_write, is_load: bus.D_is_load};
    end else begin
      sh_e_d = SH_EMPTY;
    end
  end

  // Stall-cycle counter, holding at all-ones instead of wrapping.
  always_comb begin
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset empties the shadow so all forwarding drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_e_q      <= SH_EMPTY;
      sh_m_q      <= SH_EMPTY;
      sh_w_q      <= SH_EMPTY;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sh_e_q      <= sh_e_d;
      sh_m_q      <= sh_m_d;
      sh_w_q      <= sh_w_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.D_rs1_sel      = rs1_sel_s;
  assign bus.D_rs2_sel      = rs2_sel_s;
  assign bus.f_rs1_data_out = rs1_data_s;
  assign bus.f_rs2_data_out = rs2_data_s;
  assign bus.stall          = stall_s;
  assign bus.E_bubble       = e_bubble_s;
  assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_decode_fwd_ctrl.sv
module tb_decode_fwd_ctrl;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_fwd_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  decode_fwd_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = instruction in E, 1 = M, 2 = W.
  logic       m_v  [3];
  logic [4:0] m_rd [3];
  logic       m_we [3];
  logic       m_ld [3];
  int         m_cnt;
  int         raw_stalls;

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      m_v[s] = 1'b0; m_rd[s] = 5'd0; m_we[s] = 1'b0; m_ld[s] = 1'b0;
    end
    m_cnt = 0;
    raw_stalls = 0;
  endtask

  // Walk producers youngest to oldest; a load still in E cannot supply data.
  task automatic model_fwd(input logic [4:0] rs, input logic used,
                           output logic sel, output logic [31:0] data, output logic lu);
    bit found;
    found = 1'b0; sel = 1'b0; data = 32'd0; lu = 1'b0;
    if (used && rs != 5'd0) begin
      for (int s = 0; s < 3; s++) begin
        if (!found && m_v[s] && m_we[s] && m_rd[s] == rs) begin
          if (s == 0 && m_ld[s]) begin
            lu = 1'b1;
          end else begin
            found = 1'b1;
            sel   = 1'b1;
            data  = (s == 0) ? bus.E_alu_out : (s == 1) ? bus.M_data : bus.W_data;
          end
        end
      end
    end
  endtask

  task automatic model_out(output logic s1, output logic [31:0] d1,
                           output logic s2, output logic [31:0] d2,
                           output logic st, output logic bub);
    logic lu1, lu2;
    model_fwd(bus.D_rs1_addr, bus.D_rs1_used, s1, d1, lu1);
    model_fwd(bus.D_rs2_addr, bus.D_rs2_used, s2, d2, lu2);
    st  = bus.D_valid && !bus.flush && (lu1 || lu2);
    bub = st || bus.flush;
  endtask

  task automatic model_clock();
    logic s1, s2, st, bub;
    logic [31:0] d1, d2;
    if (!rst_n) begin
      model_reset();
    end else begin
      model_out(s1, d1, s2, d2, st, bub);
      for (int s = 2; s > 0; s--) begin
        m_v[s] = m_v[s-1]; m_rd[s] = m_rd[s-1]; m_we[s] = m_we[s-1]; m_ld[s] = m_ld[s-1];
      end
      m_v[0]  = bus.D_valid && !st && !bus.flush;
      m_rd[0] = bus.D_rd; m_we[0] = bus.D_reg_write; m_ld[0] = bus.D_is_load;
      if (st) begin
        raw_stalls++;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    bus.D_valid = v; bus.D_rs1_addr = rs1; bus.D_rs2_addr = rs2;
    bus.D_rs1_used = u1; bus.D_rs2_used = u2; bus.D_rd = rd;
    bus.D_reg_write = we; bus.D_is_load = ld; bus.flush = fl;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
    bus.E_alu_out = 32'h1; bus.M_data = 32'h2; bus.W_data = 32'h3;
    #2;
    checks++; if (bus.E_bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble_flush got %0b exp 1", bus.E_bubble); end
    bus.flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.E_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %0b exp 0", bus.E_bubble); end
    checks++; if (bus.D_rs1_sel !== 1'b0 || bus.D_rs2_sel !== 1'b0) begin errors++; $display("FAIL reset_sel got %0b%0b exp 00", bus.D_rs1_sel, bus.D_rs2_sel); end
    checks++; if (bus.f_rs1_data_out !== 32'd0 || bus.f_rs2_data_out !== 32'd0) begin errors++; $display("FAIL reset_data got %0h/%0h exp 0", bus.f_rs1_data_out, bus.f_rs2_data_out); end
    checks++; if (bus.stall !== 1'b0 || bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall got %0b cnt %0d exp 0", bus.stall, bus.stall_cnt); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_alu_fwd();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.E_alu_out = 32'h11;
    #1;
    checks++; if (bus.D_rs1_sel !== 1'b1) begin errors++; $display("FAIL alu_sel got %0b exp 1", bus.D_rs1_sel); end
    checks++; if (bus.f_rs1_data_out !== 32'h11) begin errors++; $display("FAIL alu_data got %0h exp 11", bus.f_rs1_data_out); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b exp 0", bus.stall); end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.M_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.E_bubble !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b/%0b exp 1/1", bus.stall, bus.E_bubble); end
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %0b exp 0", bus.stall); end
    checks++; if (bus.D_rs2_sel !== 1'b1 || bus.f_rs2_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lu_fwd got %0b %0h exp 1 deadbeef", bus.D_rs2_sel, bus.f_rs2_data_out); end
    checks++; if (bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", bus.stall_cnt); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_priority();
    bus.E_alu_out = 32'hA; bus.M_data = 32'hB; bus.W_data = 32'hC;
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.f_rs1_data_out !== 32'hA) begin errors++; $display("FAIL prio_e_over_m got %0h exp a", bus.f_rs1_data_out); end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.D_rs1_sel !== 1'b1 || bus.f_rs1_data_out !== 32'hC) begin errors++; $display("FAIL prio_w_only got %0b %0h exp 1 c", bus.D_rs1_sel, bus.f_rs1_data_out); end
    tick();
  endtask

  task automatic test_x0_unused();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.E_alu_out = 32'h55;
    #1;
    checks++; if (bus.D_rs1_sel !== 1'b0 || bus.f_rs1_data_out !== 32'd0) begin errors++; $display("FAIL x0_fwd got %0b %0h exp 0 0", bus.D_rs1_sel, bus.f_rs1_data_out); end
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.D_rs2_sel !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL unused_rs2 got sel %0b stall %0b exp 0 0", bus.D_rs2_sel, bus.stall); end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.E_bubble !== 1'b1) begin errors++; $display("FAIL flush_hazard got %0b/%0b exp 0/1", bus.stall, bus.E_bubble); end
    tick();
    drive(1'b1, 5'd4, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.E_alu_out = 32'h1111; bus.M_data = 32'h2222; bus.W_data = 32'h3333;
    #1;
    checks++; if (bus.D_rs1_sel !== 1'b1 || bus.f_rs1_data_out !== 32'h2222) begin errors++; $display("FAIL flush_m_fwd got %0b %0h exp 1 2222", bus.D_rs1_sel, bus.f_rs1_data_out); end
    checks++; if (bus.D_rs2_sel !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL flush_killed_e got sel %0b stall %0b exp 0 0", bus.D_rs2_sel, bus.stall); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    bus.M_data = 32'h0BAD_0001;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1 got %0b exp 1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b0 || bus.f_rs1_data_out !== 32'h0BAD_0001) begin errors++; $display("FAIL b2b_release1 got %0b %0h exp 0 bad0001", bus.stall, bus.f_rs1_data_out); end
    tick();
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got %0b exp 1", bus.stall); end
    tick();
    checks++; if (bus.stall !== 1'b0 || bus.D_rs1_sel !== 1'b1) begin errors++; $display("FAIL b2b_release2 got %0b sel %0b exp 0 1", bus.stall, bus.D_rs1_sel); end
    tick();
  endtask

  task automatic test_random();
    logic s1, s2, st, bub;
    logic [31:0] d1, d2;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 7) == 0));
      bus.E_alu_out = $urandom; bus.M_data = $urandom; bus.W_data = $urandom;
      #1;
      model_out(s1, d1, s2, d2, st, bub);
      checks++;
      if (bus.D_rs1_sel !== s1 || bus.f_rs1_data_out !== d1 || bus.D_rs2_sel !== s2 ||
          bus.f_rs2_data_out !== d2 || bus.stall !== st || bus.E_bubble !== bub ||
          bus.stall_cnt !== 4'(m_cnt)) begin
        errors++;
        $display("FAIL rand_%0d got sel %0b%0b data %0h/%0h st %0b bub %0b cnt %0d exp sel %0b%0b data %0h/%0h st %0b bub %0b cnt %0d",
                 i, bus.D_rs1_sel, bus.D_rs2_sel, bus.f_rs1_data_out, bus.f_rs2_data_out,
                 bus.stall, bus.E_bubble, bus.stall_cnt, s1, s2, d1, d2, st, bub, m_cnt);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL arst_pre_stall got %0b exp 1", bus.stall); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.stall !== 1'b0 || bus.E_bubble !== 1'b0 || bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL arst_outputs got st %0b bub %0b cnt %0d exp 0 0 0", bus.stall, bus.E_bubble, bus.stall_cnt); end
    checks++; if (bus.D_rs1_sel !== 1'b0 || bus.D_rs2_sel !== 1'b0 || bus.f_rs1_data_out !== 32'd0) begin errors++; $display("FAIL arst_fwd got %0b%0b %0h exp 00 0", bus.D_rs1_sel, bus.D_rs2_sel, bus.f_rs1_data_out); end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.E_bubble !== 1'b1) begin errors++; $display("FAIL arst_bubble_flush got %0b exp 1", bus.E_bubble); end
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_saturation();
    int budget;
    budget = 0;
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
    while (raw_stalls < 20 && budget < 100) begin
      tick();
      budget++;
    end
    checks++; if (raw_stalls < 20) begin errors++; $display("FAIL sat_timeout got %0d stalls exp 20", raw_stalls); end
    checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", bus.stall_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.E_alu_out = 32'd0; bus.M_data = 32'd0; bus.W_data = 32'd0;
    model_reset();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority();
    test_x0_unused();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_fwd_ctrl.md
# decode_fwd_ctrl

Forwarding and hazard controller for the decode stage of the 5-stage pipeline. It sits directly upstream of the decode-stage operand select mux. It keeps a shadow record of the destination registers in flight in E, M and W. From that record and the current D-stage sources it produces:
- the per-operand select bits and forwarded data (`D_rs1_sel`, `D_rs2_sel`, `f_rs1_data_out`, `f_rs2_data_out`);
- the load-use stall and E-stage bubble controls;
- a saturating stall-cycle counter.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 32, stall counter width
- `clk` in 1, rising-edge clock
- `rst_n` in 1, reset, asynchronous, active-low
- `D_valid` in 1, D-stage holds a real instruction
- `D_rs1_addr` in 5, source register 1 index
- `D_rs2_addr` in 5, source register 2 index
- `D_rs1_used` in 1, instruction reads rs1
- `D_rs2_used` in 1, instruction reads rs2
- `D_rd` in 5, destination register index
- `D_reg_write` in 1, instruction writes rd
- `D_is_load` in 1, instruction is a load
- `flush` in 1, branch/jump redirect resolved in E; kills D and E
- `E_alu_out` in XLEN, E-stage result, combinational this cycle
- `M_data` in XLEN, M-stage result (ALU result or load data)
- `W_data` in XLEN, W-stage write-back data
- `D_rs1_sel` out 1, 1 = use `f_rs1_data_out`
- `D_rs2_sel` out 1, 1 = use `f_rs2_data_out`
- `f_rs1_data_out` out XLEN, forwarded rs1 value
- `f_rs2_data_out` out XLEN, forwarded rs2 value
- `stall` out 1, hold PC and the F/D register
- `E_bubble` out 1, insert a NOP into the D/E register
- `stall_cnt` out CNT_W, count of load-use stall cycles

## Operation
- **Shadow pipeline.** Three entries, `sh_E`, `sh_M`, `sh_W`. Each entry holds {valid, rd, reg_write, is_load}.
- **Shadow advance, every clock.**
  - `sh_W ← sh_M`
  - `sh_M ← sh_E`
  - `sh_E ← D` fields gated by `D_valid & ~stall & ~flush`. Otherwise `sh_E` becomes an invalid entry.
- **Per-operand match.** For operand i and stage s, `hit_s = used_i & sh_s.valid & sh_s.reg_write & (sh_s.rd == rs_i) & (rs_i != 0)`.
- **Priority.** E > M > W; the youngest producer wins.
  - E hit, not a load: sel = 1, data = `E_alu_out`.
  - E hit, load: raise the load-use hazard; sel and data follow the M/W lookup.
  - Otherwise M hit: sel = 1, data = `M_data`.
  - Otherwise W hit: sel = 1, data = `W_data`.
  - Otherwise: sel = 0, data = 0.
- **Hazard outputs.**
  - `stall = D_valid & ~flush & (load-use on rs1 | load-use on rs2)`.
  - `E_bubble = stall | flush`.
- **Register x0.** Never forwarded and never causes a stall.
- **Flush with a hazard present.** `flush` wins: `stall` = 0 and `E_bubble` = 1.
- **Stall counter.** `stall_cnt` increments by 1 in each cycle where `stall` = 1. It saturates at all-ones and does not wrap.

## Timing
- **Combinational outputs.** Selects, forwarded data, `stall` and `E_bubble` are combinational from the shadow state and the D/E/M/W inputs. There is no added latency: they are valid in the same cycle as the D-stage inputs.
- **Registered state.** The shadow entries and `stall_cnt` update on the rising edge of `clk`.
- **Load-use sequence.**
  - Cycle n: load in E, dependent instruction in D → `stall` = 1 for exactly one cycle.
  - Cycle n+1: the load is in M → `sel` = 1, data = `M_data`, `stall` = 0.
- **Back-to-back loads.** Two dependent loads each stall exactly one cycle.
- **Reset.** Asserting `rst_n` low clears all shadow valid bits and `stall_cnt` immediately, including mid-stall. Outputs while in reset:
  - `D_rs1_sel` = `D_rs2_sel` = 0
  - `f_rs*_data_out` = 0
  - `stall` = 0
  - `E_bubble` = `flush`
  - `stall_cnt` = 0
- **Write-back without a W hit.** The register file handles write-before-read, but W forwarding is still required so behaviour does not depend on the register-file write edge.

## Structure
- **Shared pipeline package** holds:
  - `XLEN` and the register-index width constant (5);
  - the `shadow_entry_t` struct {valid, rd, reg_write, is_load}.
- **Sub-module `fwd_lookup`.** One instance per operand, so two in total. Inputs: the source index, `used`, and the three shadow entries plus E/M/W data. Outputs: `sel`, `data`, `load_use`.
- **Top level** holds the shadow registers, the stall/bubble logic and the counter.

## Test plan
1. **ALU → dependent ALU, back to back.** `add x5` in E with `E_alu_out` = 0x11; D reads `rs1` = x5 → `D_rs1_sel` = 1, `f_rs1_data_out` = 0x11, `stall` = 0.
2. **Load-use.** `lw x7` in E; D reads `rs2` = x7 → `stall` = 1 and `E_bubble` = 1 for one cycle. Next cycle `D_rs2_sel` = 1, `f_rs2_data_out` = `M_data` = 0xDEAD_BEEF, and `stall_cnt` = 1.
3. **Priority and W forwarding.**
   - x3 written in both E (0xA) and M (0xB) → forwarded value is 0xA.
   - x3 only in W (0xC) → forwarded value is 0xC.
4. **x0 and unused operands.**
   - `rd` = x0 in E, D reads x0 → sel = 0.
   - A matching `rs2` with `D_rs2_used` = 0 → sel = 0 and no stall.
5. **Flush over hazard.** Load-use present and `flush` = 1 in the same cycle → `stall` = 0, `E_bubble` = 1. Next cycle `sh_E` is invalid and produces no forwarding.
6. **Async reset and counter saturation.**
   - Assert `rst_n` low mid-stall → outputs go to their reset values without waiting for a clock edge.
   - With `CNT_W` = 4, 20 stall cycles → `stall_cnt` = 15.
